// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the ALU always wins, and MUL/DIV/LSU results drain round-robin from small FIFOs.
// Optional per-source blocked-cycle counters are built when WB_ARB_STATS_EN is defined.
module wb_port_arbiter #(
  parameter int XLEN                = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH          = 2,
  parameter int STAT_WIDTH          = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_rd_addr,
  input  logic [XLEN-1:0]                alu_data,
  input  logic                           mul_valid,
  output logic                           mul_ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mul_rd_addr,
  input  logic [XLEN-1:0]                mul_data,
  input  logic                           div_valid,
  output logic                           div_ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] div_rd_addr,
  input  logic [XLEN-1:0]                div_data,
  input  logic                           lsu_valid,
  output logic                           lsu_ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] lsu_rd_addr,
  input  logic [XLEN-1:0]                lsu_data,
  output logic [XLEN-1:0]                exu_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr,
  output logic                           exu_wb_rd_wr_en,
  output logic [1:0]                     wb_src,
  output logic                           mul_pending,
  output logic                           div_pending,
  output logic                           lsu_pending
`ifdef WB_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]          mul_blocked_cnt,
  output logic [STAT_WIDTH-1:0]          div_blocked_cnt,
  output logic [STAT_WIDTH-1:0]          lsu_blocked_cnt
`endif
);

  localparam int RW    = REG_FILE_ADDR_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Source index doubles as wb_src-1: 0=LSU, 1=MUL, 2=DIV.
  localparam logic [1:0] IDX_LSU = 2'd0;
  localparam logic [1:0] IDX_MUL = 2'd1;
  localparam logic [1:0] IDX_DIV = 2'd2;

  logic [2:0]           w_in_valid;
  logic [2:0][RW-1:0]   w_in_rd;
  logic [2:0][XLEN-1:0] w_in_data;
  logic [2:0]           w_ready;
  logic [2:0]           w_nonempty;
  logic [2:0]           w_grant;
  logic [2:0][RW-1:0]   w_head_rd;
  logic [2:0][XLEN-1:0] w_head_data;

  assign w_in_valid = {div_valid, mul_valid, lsu_valid};
  assign w_in_rd    = {div_rd_addr, mul_rd_addr, lsu_rd_addr};
  assign w_in_data  = {div_data, mul_data, lsu_data};

  assign lsu_ready   = w_ready[IDX_LSU];
  assign mul_ready   = w_ready[IDX_MUL];
  assign div_ready   = w_ready[IDX_DIV];
  assign lsu_pending = w_nonempty[IDX_LSU];
  assign mul_pending = w_nonempty[IDX_MUL];
  assign div_pending = w_nonempty[IDX_DIV];

  function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fifo
      logic [XLEN-1:0]  r_mem_data [FIFO_DEPTH];
      logic [RW-1:0]    r_mem_rd   [FIFO_DEPTH];
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [CNT_W-1:0] r_count;
      logic             w_push;
      logic             w_pop;

      assign w_ready[gi]     = (r_count != FULL_CNT);
      assign w_nonempty[gi]  = (r_count != '0);
      // Writes to x0 complete the handshake but are dropped here.
      assign w_push          = w_in_valid[gi] & w_ready[gi] & (w_in_rd[gi] != '0);
      assign w_pop           = w_grant[gi];
      assign w_head_data[gi] = r_mem_data[r_rptr];
      assign w_head_rd[gi]   = r_mem_rd[r_rptr];

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem_data[r_wptr] <= w_in_data[gi];
          r_mem_rd[r_wptr]   <= w_in_rd[gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push) r_wptr <= f_ptr_next(r_wptr);
          if (w_pop)  r_rptr <= f_ptr_next(r_rptr);
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  logic [1:0] r_rr_ptr;
  logic       w_alu_win;
  logic       w_fifo_win;
  logic [1:0] w_grant_idx;
  logic [1:0] w_order [3];

  assign w_alu_win = alu_valid & (alu_rd_addr != '0);

  always_comb begin
    case (r_rr_ptr)
      IDX_LSU: w_order = '{IDX_MUL, IDX_DIV, IDX_LSU};
      IDX_MUL: w_order = '{IDX_DIV, IDX_LSU, IDX_MUL};
      default: w_order = '{IDX_LSU, IDX_MUL, IDX_DIV};
    endcase
    w_fifo_win  = 1'b0;
    w_grant_idx = r_rr_ptr;
    // Scan backwards so the earliest candidate in round-robin order wins.
    if (!w_alu_win) begin
      for (int k = 2; k >= 0; k--) begin
        if (w_nonempty[w_order[k]]) begin
          w_fifo_win  = 1'b1;
          w_grant_idx = w_order[k];
        end
      end
    end
    w_grant = w_fifo_win ? (3'b001 << w_grant_idx) : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= IDX_DIV;
    end else if (w_fifo_win) begin
      r_rr_ptr <= w_grant_idx;
    end
  end

  logic [XLEN-1:0] r_wb_data;
  logic [RW-1:0]   r_wb_rd;
  logic            r_wb_wr_en;
  logic [1:0]      r_wb_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_wr_en <= 1'b0;
      r_wb_src   <= 2'd0;
    end else if (w_alu_win) begin
      r_wb_data  <= alu_data;
      r_wb_rd    <= alu_rd_addr;
      r_wb_wr_en <= 1'b1;
      r_wb_src   <= 2'd0;
    end else if (w_fifo_win) begin
      r_wb_data  <= w_head_data[w_grant_idx];
      r_wb_rd    <= w_head_rd[w_grant_idx];
      r_wb_wr_en <= 1'b1;
      r_wb_src   <= w_grant_idx + 2'd1;
    end else begin
      r_wb_wr_en <= 1'b0;
    end
  end

  assign exu_wb_data     = r_wb_data;
  assign exu_wb_rd_addr  = r_wb_rd;
  assign exu_wb_rd_wr_en = r_wb_wr_en;
  assign wb_src          = r_wb_src;

`ifdef WB_ARB_STATS_EN
  logic [2:0][STAT_WIDTH-1:0] w_blocked_cnt;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_stats
      logic [STAT_WIDTH-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_nonempty[gi] && !w_grant[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + STAT_WIDTH'(1);
        end
      end

      assign w_blocked_cnt[gi] = r_cnt;
    end
  endgenerate

  assign lsu_blocked_cnt = w_blocked_cnt[IDX_LSU];
  assign mul_blocked_cnt = w_blocked_cnt[IDX_MUL];
  assign div_blocked_cnt = w_blocked_cnt[IDX_DIV];
`endif

endmodule
